// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request, ALU operand/result and completion signals of the execute-stage issue controller
interface alu_issue_ctrl_if #(parameter int N = 8);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_alu_op;
    logic [2:0]   in_funct3;
    logic         in_funct7b5;
    logic [N-1:0] in_op_a;
    logic [N-1:0] in_op_b;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_sel;
    logic [N-1:0] alu_result;
    logic         alu_zero;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result;
    logic         out_taken;
    logic         out_illegal;

    // controller side: drives the ALU operands and the completion handshake
    modport master (
        input  in_valid, in_alu_op, in_funct3, in_funct7b5, in_op_a, in_op_b,
        input  alu_result, alu_zero, out_ready,
        output in_ready, alu_a, alu_b, alu_sel,
        output out_valid, out_result, out_taken, out_illegal
    );

    // environment side: decode stage, ALU and result consumer
    modport slave (
        output in_valid, in_alu_op, in_funct3, in_funct7b5, in_op_a, in_op_b,
        output alu_result, alu_zero, out_ready,
        input  in_ready, alu_a, alu_b, alu_sel,
        input  out_valid, out_result, out_taken, out_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes ALUOp/funct3/funct7[5] into an ALU select, drives registered operands and returns result/branch-taken
module alu_issue_ctrl #(
    parameter int N = 8
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    alu_issue_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
    typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} br_t;

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_ILL = 4'b1111;

    state_t       state_q, state_d;
    br_t          br_q, br_d, dec_br;
    logic [N-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]   sel_q, sel_d, dec_sel;
    logic         ill_q, ill_d, dec_ill;
    logic         valid_q, valid_d, taken_q, taken_d, oill_q, oill_d;

    // decode the incoming request; anything unlisted falls through as illegal
    always_comb begin
        dec_sel = SEL_ILL;
        dec_ill = 1'b1;
        dec_br  = BR_NONE;
        case (bus.in_alu_op)
            2'b00: begin
                dec_sel = SEL_ADD;
                dec_ill = 1'b0;
            end
            2'b01: if (bus.in_funct3[2:1] == 2'b00) begin
                dec_sel = SEL_SUB;
                dec_ill = 1'b0;
                dec_br  = bus.in_funct3[0] ? BR_NE : BR_EQ;
            end
            default: case (bus.in_funct3)
                3'b000: begin
                    dec_sel = (!bus.in_alu_op[0] && bus.in_funct7b5) ? SEL_SUB : SEL_ADD;
                    dec_ill = 1'b0;
                end
                3'b111: begin
                    dec_sel = SEL_AND;
                    dec_ill = 1'b0;
                end
                3'b110: begin
                    dec_sel = SEL_OR;
                    dec_ill = 1'b0;
                end
                default: ;
            endcase
        endcase
    end

    // next-state: accept in IDLE, sample the ALU in EXEC, wait for the consumer in HOLD; flush overrides all
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        ill_d   = ill_q;
        br_d    = br_q;
        res_d   = res_q;
        valid_d = valid_q;
        taken_d = taken_q;
        oill_d  = oill_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d     = bus.in_op_a;
                b_d     = bus.in_op_b;
                sel_d   = dec_sel;
                ill_d   = dec_ill;
                br_d    = dec_br;
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = bus.alu_result;
                oill_d  = ill_q;
                taken_d = (br_q == BR_EQ) ? bus.alu_zero : (br_q == BR_NE) ? !bus.alu_zero : 1'b0;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: if (bus.out_ready) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
            a_d     = a_q;
            b_d     = b_q;
            sel_d   = sel_q;
            ill_d   = ill_q;
            br_d    = br_q;
        end
    end

    // state and output registers; reset drops any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= SEL_AND;
            ill_q   <= 1'b0;
            br_q    <= BR_NONE;
            res_q   <= '0;
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            oill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            ill_q   <= ill_d;
            br_q    <= br_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            taken_q <= taken_d;
            oill_q  <= oill_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_sel     = sel_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_result  = res_q;
    assign bus.out_taken   = taken_q;
    assign bus.out_illegal = oill_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed requests against a scoreboard, with a behavioural ALU closing the loop
module tb_alu_issue_ctrl;
    logic clk;
    logic rst;
    logic flush;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] res;
        logic       taken;
        logic       ill;
    } exp_t;

    exp_t sb[$];

    alu_issue_ctrl_if #(.N(8)) bus ();

    alu_issue_ctrl #(.N(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational ALU: AND, OR, ADD, SUB, anything else returns 0
    always_comb begin
        bus.alu_result = 8'h00;
        case (bus.alu_sel)
            4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
            4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
            4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
            default: bus.alu_result = 8'h00;
        endcase
        bus.alu_zero = (bus.alu_result == 8'h00);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every completed output handshake is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got result %0h, expected no output", bus.out_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_sel", bus.alu_sel, e.sel);
                chk("mon_result", bus.out_result, e.res);
                chk("mon_taken", bus.out_taken, e.taken);
                chk("mon_illegal", bus.out_illegal, e.ill);
            end
        end
    end

    // watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive(logic [7:0] a, logic [7:0] b, logic [1:0] op, logic [2:0] f3, logic f7);
        bus.in_op_a     = a;
        bus.in_op_b     = b;
        bus.in_alu_op   = op;
        bus.in_funct3   = f3;
        bus.in_funct7b5 = f7;
        bus.in_valid    = 1'b1;
    endtask

    // one request with out_ready high; called #1 after a rising edge while IDLE
    task automatic run_op(string nm, logic [7:0] a, logic [7:0] b, logic [1:0] op, logic [2:0] f3,
                          logic f7, logic [3:0] sel, logic [7:0] res, logic tk, logic il);
        exp_t e;
        chk({nm, "_ready_idle"}, bus.in_ready, 1);
        drive(a, b, op, f3, f7);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        e.sel = sel;
        e.res = res;
        e.taken = tk;
        e.ill = il;
        sb.push_back(e);
        chk({nm, "_sel"}, bus.alu_sel, sel);
        chk({nm, "_busy"}, bus.in_ready, 0);
        chk({nm, "_valid_exec"}, bus.out_valid, 0);
        @(posedge clk);
        #1;
        chk({nm, "_valid_hold"}, bus.out_valid, 1);
        @(posedge clk);
        #1;
        chk({nm, "_valid_done"}, bus.out_valid, 0);
        chk({nm, "_ready_done"}, bus.in_ready, 1);
    endtask

    initial begin
        exp_t e;
        rst             = 1'b0;
        flush           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_op_a     = 8'h00;
        bus.in_op_b     = 8'h00;
        bus.in_alu_op   = 2'b00;
        bus.in_funct3   = 3'b000;
        bus.in_funct7b5 = 1'b0;
        bus.out_ready   = 1'b1;
        #1;
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_sel", bus.alu_sel, 0);
        chk("rst_a", bus.alu_a, 0);
        chk("rst_result", bus.out_result, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_op("add",      8'h7F, 8'h01, 2'b10, 3'b000, 1'b0, 4'b0010, 8'h80, 1'b0, 1'b0);
        run_op("sub_wrap", 8'h00, 8'h01, 2'b10, 3'b000, 1'b1, 4'b0110, 8'hFF, 1'b0, 1'b0);
        run_op("andi",     8'hF0, 8'h3C, 2'b11, 3'b111, 1'b0, 4'b0000, 8'h30, 1'b0, 1'b0);
        run_op("ori",      8'hF0, 8'h3C, 2'b11, 3'b110, 1'b0, 4'b0001, 8'hFC, 1'b0, 1'b0);
        run_op("addi_f7",  8'h10, 8'h05, 2'b11, 3'b000, 1'b1, 4'b0010, 8'h15, 1'b0, 1'b0);
        run_op("ldst",     8'hFE, 8'h03, 2'b00, 3'b010, 1'b1, 4'b0010, 8'h01, 1'b0, 1'b0);
        run_op("beq_t",    8'h55, 8'h55, 2'b01, 3'b000, 1'b0, 4'b0110, 8'h00, 1'b1, 1'b0);
        run_op("bne_nt",   8'h55, 8'h55, 2'b01, 3'b001, 1'b0, 4'b0110, 8'h00, 1'b0, 1'b0);
        run_op("bne_t",    8'h55, 8'h54, 2'b01, 3'b001, 1'b0, 4'b0110, 8'h01, 1'b1, 1'b0);
        run_op("beq_nt",   8'h55, 8'h54, 2'b01, 3'b000, 1'b0, 4'b0110, 8'h01, 1'b0, 1'b0);
        run_op("br_ill",   8'h55, 8'h55, 2'b01, 3'b100, 1'b0, 4'b1111, 8'h00, 1'b0, 1'b1);
        run_op("r_ill",    8'h12, 8'h34, 2'b10, 3'b100, 1'b0, 4'b1111, 8'h00, 1'b0, 1'b1);

        // backpressure: second request stays pending until the first is consumed
        bus.out_ready = 1'b0;
        drive(8'h12, 8'h34, 2'b10, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        e.sel = 4'b0010;
        e.res = 8'h46;
        e.taken = 1'b0;
        e.ill = 1'b0;
        sb.push_back(e);
        drive(8'h0F, 8'h3C, 2'b10, 3'b111, 1'b0);
        chk("bp_a_first", bus.alu_a, 8'h12);
        @(posedge clk);
        #1;
        chk("bp_valid", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_ready", bus.in_ready, 0);
            chk("bp_hold_result", bus.out_result, 8'h46);
            chk("bp_hold_a", bus.alu_a, 8'h12);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", bus.out_valid, 0);
        chk("bp_release_ready", bus.in_ready, 1);
        chk("bp_second_not_taken", bus.alu_a, 8'h12);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp_second_a", bus.alu_a, 8'h0F);
        chk("bp_second_busy", bus.in_ready, 0);
        e.sel = 4'b0000;
        e.res = 8'h0C;
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk("bp_second_valid", bus.out_valid, 1);
        @(posedge clk);
        #1;
        chk("bp_second_done", bus.out_valid, 0);

        // flush while in EXEC drops the request
        drive(8'h01, 8'h02, 2'b10, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("fl_exec_busy", bus.in_ready, 0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl_idle", bus.in_ready, 1);
        chk("fl_valid", bus.out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("fl_no_valid", bus.out_valid, 0);
        end

        // flush beats a simultaneous request in IDLE
        drive(8'h77, 8'h01, 2'b00, 3'b000, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_req_ready", bus.in_ready, 1);
        chk("fl_req_a", bus.alu_a, 8'h01);

        // asynchronous reset while holding a result
        bus.out_ready = 1'b0;
        drive(8'hAA, 8'h11, 2'b11, 3'b110, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rh_valid", bus.out_valid, 1);
        chk("rh_result", bus.out_result, 8'hBB);
        #2;
        rst = 1'b0;
        #1;
        chk("rh_rst_valid", bus.out_valid, 0);
        chk("rh_rst_ready", bus.in_ready, 1);
        chk("rh_rst_a", bus.alu_a, 0);
        chk("rh_rst_b", bus.alu_b, 0);
        chk("rh_rst_sel", bus.alu_sel, 0);
        chk("rh_rst_result", bus.out_result, 0);
        chk("rh_rst_taken", bus.out_taken, 0);
        chk("rh_rst_illegal", bus.out_illegal, 0);
        #1;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rh_after_valid", bus.out_valid, 0);

        run_op("post_rst", 8'h03, 8'h04, 2'b10, 3'b000, 1'b0, 4'b0010, 8'h07, 1'b0, 1'b0);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
